// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with bounded lock
//
// Shares one single-port data memory between port 0 (CPU load/store) and
// port 1 (loader/debug). Grants are combinational and each grant is a
// complete single-cycle transfer. A port may assert lock with a granted
// request to keep ownership for an atomic read-modify-write; ownership is
// forcibly released after MAX_LOCK locked cycles.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   req/we/lock/addr/wdata per-port request inputs (suffix 0 / 1)
//   gnt                    per-port transfer accepted this cycle
//   rvalid/rdata           per-port read response, one cycle after the grant
//   mem_address            memory byte address (0 when nothing is granted)
//   mem_data_in            memory write data (0 when nothing is granted)
//   mem_write_enable       memory write strobe
//   mem_data_out           memory combinational read data
//   owner_check            debug {locked, lock owner}
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [1:0]            owner_check
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOCKED0 = 2'd1;
    localparam logic [1:0] ST_LOCKED1 = 2'd2;

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            lock_cnt_q, lock_cnt_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  gnt0_c;
    logic                  gnt1_c;

    // Grant selection. last_grant_q names the port that won most recently,
    // so on a tie in IDLE the other port wins. Grants are forced low while
    // reset is held so no write can slip into memory during reset.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        case (state_q)
            ST_LOCKED0: gnt0_c = req0;
            ST_LOCKED1: gnt1_c = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0_c = last_grant_q;
                    gnt1_c = ~last_grant_q;
                end else begin
                    gnt0_c = req0;
                    gnt1_c = req1;
                end
            end
        endcase
        if (!reset) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    // Memory drive from the granted port; idle bus is all zeros.
    always_comb begin
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        if (gnt0_c) begin
            mem_address      = addr0;
            mem_data_in      = wdata0;
            mem_write_enable = we0;
        end else if (gnt1_c) begin
            mem_address      = addr1;
            mem_data_in      = wdata1;
            mem_write_enable = we1;
        end
    end

    // Ownership state machine and lock counter.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;

        if (gnt0_c) begin
            last_grant_d = 1'b0;
        end else if (gnt1_c) begin
            last_grant_d = 1'b1;
        end

        case (state_q)
            ST_LOCKED0: begin
                if (!lock0) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q == LOCK_LIMIT) begin
                    // Forced release: mark port 0 as last winner so port 1
                    // takes the next tie.
                    state_d      = ST_IDLE;
                    lock_cnt_d   = 8'd0;
                    last_grant_d = 1'b0;
                end else if (lock_cnt_q != 8'hFF) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            ST_LOCKED1: begin
                if (!lock1) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q == LOCK_LIMIT) begin
                    state_d      = ST_IDLE;
                    lock_cnt_d   = 8'd0;
                    last_grant_d = 1'b1;
                end else if (lock_cnt_q != 8'hFF) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: begin
                // Lock only takes hold together with an actual grant.
                state_d    = ST_IDLE;
                lock_cnt_d = 8'd0;
                if (gnt0_c && lock0) begin
                    state_d    = ST_LOCKED0;
                    lock_cnt_d = 8'd1;
                end else if (gnt1_c && lock1) begin
                    state_d    = ST_LOCKED1;
                    lock_cnt_d = 8'd1;
                end
            end
        endcase
    end

    // Read response: capture memory data on the edge ending a granted read.
    always_comb begin
        rvalid0_d = gnt0_c & ~we0;
        rvalid1_d = gnt1_c & ~we1;
        rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= 8'd0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign gnt0        = gnt0_c;
    assign gnt1        = gnt1_c;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign owner_check = {state_q != ST_IDLE, state_q == ST_LOCKED1};

endmodule
